// File: rtl/spi_slave_tx_splitter.sv
`default_nettype none
// ============================================================================
// Module  : spi_slave_tx_splitter
// Purpose : queues 64-bit result words and preloads them MSB byte first into
//           the SPI slave TX port; optional idle fill pattern via SPI_TX_FILL_EN.
// Revision: 1.0  initial release
// ============================================================================
module spi_slave_tx_splitter #(
   parameter int         DEPTH     = 4,
   parameter logic [7:0] FILL_BYTE = 8'hA5
) (
   input  logic        clk,
   input  logic        rst_,
   input  logic        i_Word_DV,
   input  logic [63:0] i_Word,
   output logic        o_Word_Ready,
   input  logic        i_RX_DV,
   input  logic        i_SPI_CS_n,
   output logic        o_TX_DV,
   output logic [7:0]  o_TX_Byte,
   output logic        o_Irq,
   output logic        o_Overflow
);

   localparam int           AW       = $clog2(DEPTH);
   localparam logic [AW:0]  FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]  CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = (AW)'(1);
`ifdef SPI_TX_FILL_EN
   localparam bit FILL_EN = 1'b1;
`else
   localparam bit FILL_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   logic [63:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [AW:0]   count_next;
   state_t        state;
   logic [2:0]    idx;
   logic          cs_meta;
   logic          cs_sync;
   logic          cs_prev;

   logic          full;
   logic          push;
   logic          pop;
   logic          cs_rise;
   logic          rewind;
   logic [63:0]   head;
   logic [5:0]    byte_lsb;
   logic [7:0]    head_byte;

   assign full      = (count == FULL_CNT);
   assign push      = i_Word_DV & ~full;
   assign pop       = (state == S_WAIT) & i_RX_DV & (idx == 3'd7);
   assign cs_rise   = cs_sync & ~cs_prev;
   // Completing the last byte outranks a deselect; otherwise a partial word is rewound.
   assign rewind    = cs_rise & (idx != 3'd0) & ~pop;
   assign head      = mem[rd_ptr];
   assign byte_lsb  = {~idx, 3'b000};
   assign head_byte = head[byte_lsb +: 8];

   always_comb begin
      count_next = count;
      if (push && !pop) begin
         count_next = count + CNT_ONE;
      end else if (!push && pop) begin
         count_next = count - CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= i_Word;
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         o_Word_Ready <= 1'b1;
         o_Irq        <= 1'b0;
         o_Overflow   <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         count        <= count_next;
         o_Word_Ready <= (count_next != FULL_CNT);
         o_Irq        <= (count != '0);
         if (i_Word_DV && full) begin
            o_Overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         cs_meta <= 1'b1;
         cs_sync <= 1'b1;
         cs_prev <= 1'b1;
      end else begin
         cs_meta <= i_SPI_CS_n;
         cs_sync <= cs_meta;
         cs_prev <= cs_sync;
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state     <= S_IDLE;
         idx       <= 3'd0;
         o_TX_DV   <= 1'b0;
         o_TX_Byte <= 8'h00;
      end else begin
         o_TX_DV <= 1'b0;
         if (rewind) begin
            idx   <= 3'd0;
            state <= S_IDLE;
         end else begin
            case (state)
               S_IDLE: begin
                  if (count != '0) begin
                     state <= S_LOAD;
                  end else if (FILL_EN && i_RX_DV) begin
                     o_TX_DV   <= 1'b1;
                     o_TX_Byte <= FILL_BYTE;
                  end
               end
               S_LOAD: begin
                  o_TX_DV   <= 1'b1;
                  o_TX_Byte <= head_byte;
                  state     <= S_WAIT;
               end
               S_WAIT: begin
                  if (i_RX_DV) begin
                     if (idx == 3'd7) begin
                        idx   <= 3'd0;
                        state <= S_IDLE;
                     end else begin
                        idx   <= idx + 3'd1;
                        state <= S_LOAD;
                     end
                  end
               end
               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_tx_splitter.sv
`default_nettype none
// ============================================================================
// Module  : tb_spi_slave_tx_splitter
// Purpose : directed self-checking bench for spi_slave_tx_splitter.
// Revision: 1.0  initial release
// ============================================================================
module tb_spi_slave_tx_splitter;

   logic        clk = 1'b0;
   logic        rst_ = 1'b1;
   logic        i_Word_DV = 1'b0;
   logic [63:0] i_Word = '0;
   logic        o_Word_Ready;
   logic        i_RX_DV = 1'b0;
   logic        i_SPI_CS_n = 1'b0;
   logic        o_TX_DV;
   logic [7:0]  o_TX_Byte;
   logic        o_Irq;
   logic        o_Overflow;

   int chk_cnt = 0;
   int pass_cnt = 0;
   int tx_cnt = 0;
   logic [7:0] tx_q [$];

   spi_slave_tx_splitter #(.DEPTH(4), .FILL_BYTE(8'hA5)) dut (
      .clk          (clk),
      .rst_         (rst_),
      .i_Word_DV    (i_Word_DV),
      .i_Word       (i_Word),
      .o_Word_Ready (o_Word_Ready),
      .i_RX_DV      (i_RX_DV),
      .i_SPI_CS_n   (i_SPI_CS_n),
      .o_TX_DV      (o_TX_DV),
      .o_TX_Byte    (o_TX_Byte),
      .o_Irq        (o_Irq),
      .o_Overflow   (o_Overflow)
   );

   always #5 clk = ~clk;

   // Every preload strobe is captured so scenarios can consume bytes in order.
   always @(negedge clk) begin
      if (o_TX_DV === 1'b1) begin
         tx_q.push_back(o_TX_Byte);
         tx_cnt <= tx_cnt + 1;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation still running at %0t, limit 300000", $time);
      $fatal(1);
   end

   task automatic push_word(input logic [63:0] w);
      @(negedge clk);
      i_Word_DV = 1'b1;
      i_Word    = w;
      @(negedge clk);
      i_Word_DV = 1'b0;
   endtask

   task automatic rx_pulse();
      repeat (16) @(negedge clk);
      i_RX_DV = 1'b1;
      @(negedge clk);
      i_RX_DV = 1'b0;
   endtask

   // Returns X when no preload appears in time, so the caller's compare fails.
   task automatic get_tx(output logic [7:0] b);
      b = 'x;
      for (int i = 0; i < 64; i++) begin
         if (tx_q.size() != 0) begin
            b = tx_q.pop_front();
            return;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      int n0;
      rst_ = 1'b0;
      repeat (3) @(negedge clk);
      chk_cnt++; if (o_Word_Ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", o_Word_Ready); else pass_cnt++;
      chk_cnt++; if (o_TX_DV !== 1'b0) $display("FAIL reset_txdv: got %b want 0", o_TX_DV); else pass_cnt++;
      chk_cnt++; if (o_TX_Byte !== 8'h00) $display("FAIL reset_txbyte: got %h want 00", o_TX_Byte); else pass_cnt++;
      chk_cnt++; if (o_Irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", o_Irq); else pass_cnt++;
      chk_cnt++; if (o_Overflow !== 1'b0) $display("FAIL reset_ovf: got %b want 0", o_Overflow); else pass_cnt++;
      n0 = tx_cnt;
      rst_ = 1'b1;
      repeat (20) @(negedge clk);
      chk_cnt++; if (tx_cnt - n0 !== 0) $display("FAIL idle_txdv_count: got %0d want 0", tx_cnt - n0); else pass_cnt++;
      chk_cnt++; if (o_Irq !== 1'b0 || o_Word_Ready !== 1'b1 || o_Overflow !== 1'b0)
         $display("FAIL idle_flags: got irq=%b rdy=%b ovf=%b want 0 1 0", o_Irq, o_Word_Ready, o_Overflow);
      else pass_cnt++;
      tx_q.delete();
   endtask

   task automatic test_single_word();
      logic [7:0] b;
      @(negedge clk);
      i_Word_DV = 1'b1;
      i_Word    = 64'h0102_0304_0506_0708;
      @(negedge clk);
      i_Word_DV = 1'b0;
      chk_cnt++; if (o_Irq !== 1'b0) $display("FAIL lat_irq_early: got %b want 0", o_Irq); else pass_cnt++;
      @(negedge clk);
      chk_cnt++; if (o_Irq !== 1'b1 || o_TX_DV !== 1'b0)
         $display("FAIL lat_irq: got irq=%b txdv=%b want 1 0", o_Irq, o_TX_DV);
      else pass_cnt++;
      @(negedge clk);
      chk_cnt++; if (o_TX_DV !== 1'b1 || o_TX_Byte !== 8'h01)
         $display("FAIL lat_txdv: got txdv=%b byte=%h want 1 01", o_TX_DV, o_TX_Byte);
      else pass_cnt++;
      get_tx(b);
      chk_cnt++; if (b !== 8'h01) $display("FAIL single_byte0: got %h want 01", b); else pass_cnt++;
      for (int i = 1; i < 8; i++) begin
         rx_pulse();
         get_tx(b);
         chk_cnt++; if (b !== 8'(i + 1)) $display("FAIL single_byte%0d: got %h want %h", i, b, 8'(i + 1)); else pass_cnt++;
      end
      rx_pulse();
      chk_cnt++; if (o_Irq !== 1'b1) $display("FAIL single_irq_hold: got %b want 1", o_Irq); else pass_cnt++;
      @(negedge clk);
      chk_cnt++; if (o_Irq !== 1'b0) $display("FAIL single_irq_drop: got %b want 0", o_Irq); else pass_cnt++;
      repeat (20) @(negedge clk);
      chk_cnt++; if (tx_q.size() !== 0) $display("FAIL single_no_extra: got %0d extra preloads want 0", tx_q.size()); else pass_cnt++;
   endtask

   task automatic test_overflow_drain();
      logic [63:0] words [5];
      logic [63:0] got;
      logic [7:0]  b;
      words[0] = 64'h0011_2233_4455_6677;
      words[1] = 64'h8899_AABB_CCDD_EEFF;
      words[2] = 64'hDEAD_BEEF_CAFE_F00D;
      words[3] = 64'h0123_4567_89AB_CDEF;
      words[4] = 64'hFFFF_0000_FFFF_0000;
      @(negedge clk);
      i_Word_DV = 1'b1;
      i_Word    = words[0];
      for (int k = 1; k < 5; k++) begin
         @(negedge clk);
         if (k == 3) begin
            chk_cnt++; if (o_Word_Ready !== 1'b1) $display("FAIL ovf_ready_3: got %b want 1", o_Word_Ready); else pass_cnt++;
         end
         if (k == 4) begin
            chk_cnt++; if (o_Word_Ready !== 1'b0) $display("FAIL ovf_ready_4: got %b want 0", o_Word_Ready); else pass_cnt++;
         end
         i_Word = words[k];
      end
      @(negedge clk);
      i_Word_DV = 1'b0;
      chk_cnt++; if (o_Overflow !== 1'b1 || o_Word_Ready !== 1'b0)
         $display("FAIL ovf_flag: got ovf=%b rdy=%b want 1 0", o_Overflow, o_Word_Ready);
      else pass_cnt++;
      for (int w = 0; w < 4; w++) begin
         got = '0;
         for (int k = 0; k < 8; k++) begin
            get_tx(b);
            got = {got[55:0], b};
            rx_pulse();
         end
         chk_cnt++; if (got !== words[w]) $display("FAIL drain_word%0d: got %h want %h", w, got, words[w]); else pass_cnt++;
      end
      @(negedge clk);
      chk_cnt++; if (o_Irq !== 1'b0 || o_Word_Ready !== 1'b1 || o_Overflow !== 1'b1)
         $display("FAIL drain_flags: got irq=%b rdy=%b ovf=%b want 0 1 1", o_Irq, o_Word_Ready, o_Overflow);
      else pass_cnt++;
      repeat (10) @(negedge clk);
      chk_cnt++; if (tx_q.size() !== 0) $display("FAIL drain_dropped_word: got %0d extra preloads want 0", tx_q.size()); else pass_cnt++;
   endtask

   task automatic test_cs_rewind();
      logic [63:0] got;
      logic [7:0]  b;
      push_word(64'hAABB_CCDD_EEFF_1122);
      get_tx(b);
      chk_cnt++; if (b !== 8'hAA) $display("FAIL rew_first: got %h want AA", b); else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         rx_pulse();
         get_tx(b);
      end
      chk_cnt++; if (b !== 8'hDD) $display("FAIL rew_partial: got %h want DD", b); else pass_cnt++;
      @(negedge clk);
      i_SPI_CS_n = 1'b1;
      get_tx(b);
      chk_cnt++; if (b !== 8'hAA) $display("FAIL rew_restart: got %h want AA", b); else pass_cnt++;
      chk_cnt++; if (o_Irq !== 1'b1) $display("FAIL rew_irq_kept: got %b want 1", o_Irq); else pass_cnt++;
      i_SPI_CS_n = 1'b0;
      got = {56'h0, b};
      for (int i = 1; i < 8; i++) begin
         rx_pulse();
         get_tx(b);
         got = {got[55:0], b};
      end
      rx_pulse();
      chk_cnt++; if (got !== 64'hAABB_CCDD_EEFF_1122) $display("FAIL rew_word: got %h want aabbccddeeff1122", got); else pass_cnt++;
      repeat (3) @(negedge clk);
      chk_cnt++; if (o_Irq !== 1'b0 || tx_q.size() !== 0)
         $display("FAIL rew_empty: got irq=%b pending=%0d want 0 0", o_Irq, tx_q.size());
      else pass_cnt++;
   endtask

   task automatic test_cs_pop_collision();
      logic [63:0] got;
      logic [7:0]  b;
      push_word(64'h1020_3040_5060_7080);
      push_word(64'h9192_9394_9596_9798);
      get_tx(b);
      for (int i = 1; i < 8; i++) begin
         rx_pulse();
         get_tx(b);
      end
      chk_cnt++; if (b !== 8'h80) $display("FAIL col_last: got %h want 80", b); else pass_cnt++;
      repeat (4) @(negedge clk);
      // Synchronised rise is sampled on the third edge after CS goes high.
      i_SPI_CS_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      i_RX_DV = 1'b1;
      @(negedge clk);
      i_RX_DV = 1'b0;
      get_tx(b);
      chk_cnt++; if (b !== 8'h91) $display("FAIL col_next_word: got %h want 91", b); else pass_cnt++;
      chk_cnt++; if (o_Irq !== 1'b1) $display("FAIL col_irq: got %b want 1", o_Irq); else pass_cnt++;
      i_SPI_CS_n = 1'b0;
      got = {56'h0, b};
      for (int i = 1; i < 8; i++) begin
         rx_pulse();
         get_tx(b);
         got = {got[55:0], b};
      end
      rx_pulse();
      chk_cnt++; if (got !== 64'h9192_9394_9596_9798) $display("FAIL col_word2: got %h want 9192939495969798", got); else pass_cnt++;
      repeat (3) @(negedge clk);
      chk_cnt++; if (o_Irq !== 1'b0 || tx_q.size() !== 0)
         $display("FAIL col_empty: got irq=%b pending=%0d want 0 0", o_Irq, tx_q.size());
      else pass_cnt++;
   endtask

   task automatic test_fill();
      int n0;
      logic [7:0] b;
      n0 = tx_cnt;
      for (int i = 0; i < 3; i++) rx_pulse();
      repeat (5) @(negedge clk);
`ifdef SPI_TX_FILL_EN
      chk_cnt++; if (tx_cnt - n0 !== 3) $display("FAIL fill_count: got %0d want 3", tx_cnt - n0); else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         get_tx(b);
         chk_cnt++; if (b !== 8'hA5) $display("FAIL fill_byte%0d: got %h want a5", i, b); else pass_cnt++;
      end
`else
      chk_cnt++; if (tx_cnt - n0 !== 0) $display("FAIL fill_count: got %0d want 0", tx_cnt - n0); else pass_cnt++;
`endif
      chk_cnt++; if (o_Irq !== 1'b0) $display("FAIL fill_irq: got %b want 0", o_Irq); else pass_cnt++;
      tx_q.delete();
      push_word(64'h5A5A_0000_0000_0001);
      get_tx(b);
      chk_cnt++; if (b !== 8'h5A) $display("FAIL fill_then_word: got %h want 5a", b); else pass_cnt++;
   endtask

   task automatic test_overflow_clear();
      @(negedge clk);
      rst_ = 1'b0;
      @(negedge clk);
      chk_cnt++; if (o_Overflow !== 1'b0 || o_Irq !== 1'b0)
         $display("FAIL rst_clear: got ovf=%b irq=%b want 0 0", o_Overflow, o_Irq);
      else pass_cnt++;
      rst_ = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_overflow_drain();
      test_cs_rewind();
      test_cs_pop_collision();
      test_fill();
      test_overflow_clear();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
`default_nettype wire
